serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single one-bit full-adder cell and a registered carry.
- Loads two operands on a start request and adds them LSB-first, one bit per clock.
- Presents the N-bit sum and carry-out with a one-cycle done pulse.
- Sits downstream of the one-bit adder cell; trades latency for area in wide datapaths.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/serial_adder_if.sv | 23 ++
 rtl/fa_cell.sv | 16 +
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg -- shared definitions for the bit-serial adder.
//   ST_IDLE / ST_RUN / ST_DONE : state encodings
//   state_e                    : FSM state type (also used on the debug port)
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if -- request/result bundle of the bit-serial adder.
//   start      : request; accepted on a rising edge while the adder is idle or done
//   a, b, cin  : operands, only meaningful at the accepting edge
//   busy       : high while bits are being processed (start is ignored then)
//   done       : one-cycle pulse; sum/cout are valid in that cycle and hold afterwards
//   sum, cout  : registered result
// Handshake: start is a request with no ready; it is taken whenever busy is low
// at the edge. done is a valid pulse with no back-pressure.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/fa_cell.sv
// fa_cell -- combinational one-bit full adder.
//   a_i, b_i, cin_i : addend bits and carry-in
//   s_o             : sum bit
//   cout_o          : carry-out (majority of the three inputs)
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : slave side of serial_adder_if (start/a/b/cin in, busy/done/sum/cout out)
//   state_o : debug view of the FSM state
// Latency: start accepted at edge k, RUN covers edges k+1..k+WIDTH, done is
// high in the cycle after edge k+WIDTH. A start during DONE reloads directly.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus,
  output state_e         state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sreg_shift;

  fa_cell u_fa (
    .a_i    (areg_q[0]),
    .b_i    (breg_q[0]),
    .cin_i  (carry_q),
    .s_o    (bit_s),
    .cout_o (bit_c)
  );

  // New bit enters at the MSB; written as a shift of the concatenation so the
  // same expression also covers WIDTH=1.
  assign sreg_shift = WIDTH'({bit_s, sreg_q} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      sreg_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      sreg_q  <= sreg_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    sreg_d  = sreg_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          areg_d  = bus.a;
          breg_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here.
        sreg_d  = sreg_shift;
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Result registers update only on the way into DONE.
          sum_d   = sreg_shift;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  import serial_arith_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg8;
  state_e dbg1;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];
  logic [8:0] prev8;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8), .state_o(dbg8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_o(dbg1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (exp_q8.size() == 0) check("d8_unexpected_done", 32'(bus8.done), 32'd0);
      else check("d8_result", 32'({bus8.cout, bus8.sum}), 32'(exp_q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (exp_q1.size() == 0) check("d1_unexpected_done", 32'(bus1.done), 32'd0);
      else check("d1_result", 32'({bus1.cout, bus1.sum}), 32'(exp_q1.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  // One 8-bit addition; ignore_at>0 pulses start with zero operands at that RUN cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int ignore_at);
    logic [8:0] full;
    int n, busy_cnt;
    bit got;
    full = 9'(a) + 9'(b) + 9'(c);
    exp_q8.push_back(full);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom_range(0, 255));
    bus8.b = 8'($urandom_range(0, 255));
    n = 0; busy_cnt = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("d8_sum_hold_while_busy", 32'(bus8.sum), 32'(prev8[7:0]));
      if (bus8.busy === 1'b1) busy_cnt++;
      if (n == ignore_at) begin
        bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
      end else if (n == ignore_at + 1) begin
        bus8.start = 1'b0;
      end
      if (bus8.done === 1'b1) begin
        got = 1;
        check("d8_busy_low_in_done", 32'(bus8.busy), 32'd0);
      end
    end
    check("d8_done_seen", 32'(got), 32'd1);
    check("d8_latency", 32'(n), 32'd9);
    check("d8_busy_cycles", 32'(busy_cnt), 32'd8);
    @(negedge clk);
    check("d8_done_one_cycle", 32'(bus8.done), 32'd0);
    check("d8_sum_hold_after", 32'({bus8.cout, bus8.sum}), 32'(full));
    prev8 = full;
  endtask

  // Waits for a done on the 8-bit DUT, returns negedges counted (bounded).
  task automatic wait_done8(output int n);
    bit got;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus8.done === 1'b1) got = 1;
    end
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int n;
    bit got;
    exp_q1.push_back(2'(a) + 2'(b) + 2'(c));
    bus1.a = a; bus1.b = b; bus1.cin = c; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check("d1_busy_run", 32'(bus1.busy), 32'd1);
      if (bus1.done === 1'b1) got = 1;
    end
    check("d1_done_seen", 32'(got), 32'd1);
    check("d1_latency", 32'(n), 32'd2);
    @(negedge clk);
    check("d1_done_one_cycle", 32'(bus1.done), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    prev8 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_sum_cout", 32'({bus8.cout, bus8.sum}), 32'd0);
    check("rst_state", 32'(dbg8), 32'(ST_IDLE));
    check("rst_d1_out", 32'({bus1.cout, bus1.sum, bus1.done, bus1.busy}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed operands
    op8(8'h5A, 8'h3C, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    // start during RUN cycle 3 must be ignored
    op8(8'h5A, 8'h3C, 1'b1, 3);

    // back-to-back with start held high
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    exp_q8.push_back(9'h030);
    @(posedge clk); #1;
    bus8.a = 8'h7F; bus8.b = 8'h01;
    wait_done8(n);
    check("b2b_first_latency", 32'(n), 32'd9);
    exp_q8.push_back(9'h080);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8(n);
    check("b2b_spacing", 32'(n), 32'd9);
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(bus8.done), 32'd0);
    prev8 = 9'h080;

    // reset in the middle of RUN
    bus8.a = 8'hAB; bus8.b = 8'h11; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus8.busy), 32'd0);
    check("mid_rst_done", 32'(bus8.done), 32'd0);
    check("mid_rst_sum_cout", 32'({bus8.cout, bus8.sum}), 32'd0);
    check("mid_rst_state", 32'(dbg8), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    prev8 = '0;
    repeat (12) @(negedge clk);
    check("mid_rst_no_done_state", 32'(dbg8), 32'(ST_IDLE));
    op8(8'h33, 8'h44, 1'b1, 0);

    // random operands
    for (int i = 0; i < 5; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);

    // WIDTH=1 instance
    op1(1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b0, 1'b0);
    op1(1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("d8_queue_empty", 32'(exp_q8.size()), 32'd0);
    check("d1_queue_empty", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
